vend_sequencer: RTL

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_pkg.sv | 12 +
 rtl/vend_timer.sv | 17 +
 rtl/vend_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state/coin types and coin values for the vending sequencer
package vend_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCEPT, ST_VEND, ST_CHANGE} state_t;
    typedef enum logic [1:0] {COIN_NICKEL, COIN_DIME, COIN_QUARTER, COIN_SLUG} coin_t;
    localparam logic [5:0] NICKEL_VAL  = 6'd1;
    localparam logic [5:0] DIME_VAL    = 6'd2;
    localparam logic [5:0] QUARTER_VAL = 6'd5;
    function automatic logic [5:0] coin_value(input coin_t c);
        return c == COIN_NICKEL ? NICKEL_VAL : c == COIN_DIME ? DIME_VAL :
               c == COIN_QUARTER ? QUARTER_VAL : 6'd0;
    endfunction
endpackage

// File: rtl/vend_timer.sv
// vend_timer: loadable down-counter; done while the count sits at zero
module vend_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    assign o_done = r_cnt == '0;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit, item vend with ack watchdog, and paced change return
module vend_sequencer import vend_pkg::*; #(
    parameter int PRICE0       = 3,
    parameter int PRICE1       = 4,
    parameter int PRICE2       = 5,
    parameter int PRICE3       = 7,
    parameter int MAX_CREDIT   = 20,
    parameter int CHG_GAP      = 4,
    parameter int DISP_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    output logic       coin_reject,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    output logic       sel_reject,
    input  logic       cancel,
    output logic       disp_req,
    output logic [1:0] disp_item,
    input  logic       disp_ack,
    output logic       change_pulse,
    output logic       fault,
    output logic [4:0] credit,
    output logic       busy
);
    localparam int TW = $clog2(DISP_TIMEOUT + CHG_GAP + 1);
    state_t r_state, w_state_n;
    logic [5:0] r_credit, w_credit_n, r_price, w_price_n, w_coin_val, w_sel_price, w_sum;
    logic [1:0] r_disp_item, w_disp_item_n;
    logic r_disp_req, w_disp_req_n, r_coin_rej, w_coin_rej_n, r_sel_rej, w_sel_rej_n;
    logic r_chg, w_chg_n, r_fault, w_fault_n, w_load, w_done;
    logic [TW-1:0] w_load_val;
    function automatic logic [5:0] price_of(input logic [1:0] s);
        return s == 2'd0 ? 6'(PRICE0) : s == 2'd1 ? 6'(PRICE1) : s == 2'd2 ? 6'(PRICE2) : 6'(PRICE3);
    endfunction
    assign w_coin_val  = coin_value(coin_t'(coin_type));
    assign w_sel_price = price_of(sel);
    assign w_sum       = r_credit + w_coin_val;
    vend_timer #(.W(TW)) u_timer (
        .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(w_load_val), .o_done(w_done)
    );
    always_comb begin
        w_state_n = r_state;
        w_credit_n = r_credit;
        w_price_n = r_price;
        w_disp_req_n = r_disp_req;
        w_disp_item_n = r_disp_item;
        w_coin_rej_n = coin_valid;
        w_sel_rej_n = 1'b0;
        w_chg_n = 1'b0;
        w_fault_n = 1'b0;
        w_load = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE, ST_ACCEPT: begin
                if (sel_valid) begin
                    if (r_credit >= w_sel_price) begin
                        w_credit_n = r_credit - w_sel_price;
                        w_price_n = w_sel_price;
                        w_disp_item_n = sel;
                        w_disp_req_n = 1'b1;
                        w_state_n = ST_VEND;
                        w_load = 1'b1;
                        w_load_val = TW'(DISP_TIMEOUT - 1);
                    end else w_sel_rej_n = 1'b1;
                end else if (cancel && r_state == ST_ACCEPT) begin
                    w_credit_n = r_credit - 6'd1;
                    w_chg_n = 1'b1;
                    w_state_n = ST_CHANGE;
                    w_load = 1'b1;
                    w_load_val = TW'(CHG_GAP - 1);
                end else if (coin_valid && coin_type != COIN_SLUG && w_sum <= 6'(MAX_CREDIT)) begin
                    w_credit_n = w_sum;
                    w_coin_rej_n = 1'b0;
                    w_state_n = ST_ACCEPT;
                end
            end
            ST_VEND: begin
                w_sel_rej_n = sel_valid;
                if (disp_ack) begin
                    w_disp_req_n = 1'b0;
                    w_state_n = r_credit != '0 ? ST_CHANGE : ST_IDLE;
                    w_chg_n = r_credit != '0;
                    w_credit_n = r_credit != '0 ? r_credit - 6'd1 : r_credit;
                    w_load = 1'b1;
                    w_load_val = TW'(CHG_GAP - 1);
                end else if (w_done) begin
                    // watchdog expired: refund the price and pay it all back as change
                    w_disp_req_n = 1'b0;
                    w_fault_n = 1'b1;
                    w_credit_n = r_credit + r_price - 6'd1;
                    w_chg_n = 1'b1;
                    w_state_n = ST_CHANGE;
                    w_load = 1'b1;
                    w_load_val = TW'(CHG_GAP - 1);
                end
            end
            ST_CHANGE: begin
                w_sel_rej_n = sel_valid;
                if (r_credit == '0) w_state_n = ST_IDLE;
                else if (w_done) begin
                    w_credit_n = r_credit - 6'd1;
                    w_chg_n = 1'b1;
                    w_load = 1'b1;
                    w_load_val = TW'(CHG_GAP - 1);
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= ST_IDLE;
            r_credit <= '0;
            r_price <= '0;
            r_disp_req <= 1'b0;
            r_disp_item <= '0;
            r_coin_rej <= 1'b0;
            r_sel_rej <= 1'b0;
            r_chg <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_credit <= w_credit_n;
            r_price <= w_price_n;
            r_disp_req <= w_disp_req_n;
            r_disp_item <= w_disp_item_n;
            r_coin_rej <= w_coin_rej_n;
            r_sel_rej <= w_sel_rej_n;
            r_chg <= w_chg_n;
            r_fault <= w_fault_n;
        end
    assign coin_reject  = r_coin_rej;
    assign sel_reject   = r_sel_rej;
    assign disp_req     = r_disp_req;
    assign disp_item    = r_disp_item;
    assign change_pulse = r_chg;
    assign fault        = r_fault;
    assign credit       = r_credit[4:0];
    assign busy         = r_state == ST_VEND || r_state == ST_CHANGE;
endmodule
